// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sharing of one cordic core among NREQ requesters.
// Optional WAIT watchdog is enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int ANGLE_W = 10,
    parameter int RES_W   = 17,
    parameter int TIMEOUT = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*ANGLE_W-1:0]   req_angle,
    output logic [NREQ-1:0]           ack,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [RES_W-1:0]          rsp_cos,
    output logic [RES_W-1:0]          rsp_sin,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      cor_start,
    output logic [31:0]               cor_z0,
    input  logic                      cor_done,
    input  logic [RES_W-1:0]          cor_cos,
    input  logic [RES_W-1:0]          cor_sin,
    output logic                      err_timeout
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [ID_W-1:0] ptr, id_q, pick;
    logic [ANGLE_W-1:0] angle_q;
    logic found, first_q, done_ok, expire;
    // a done seen in the first WAIT cycle may be left over from the previous operation
    assign done_ok = state == WAIT && !first_q && cor_done;
    assign cor_z0 = 32'(angle_q) << (32 - ANGLE_W);
    // first asserted request searching upward from ptr, wrapping modulo NREQ
    always_comb begin
        int j;
        j = 0;
        pick = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                pick = ID_W'(j);
            end
        end
    end
    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = found ? START : IDLE;
            START:   state_nx = WAIT;
            WAIT:    state_nx = (done_ok || expire) ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    // handshake outputs decoded from the registered state
    always_comb begin
        ack = '0;
        ack[id_q] = state == START;
        cor_start = state == START;
        busy = state != IDLE;
        rsp_valid = state == RESP;
    end
    // grant capture, pointer rotation and response capture
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
            id_q <= '0;
            angle_q <= '0;
            first_q <= 1'b0;
            rsp_id <= '0;
            rsp_cos <= '0;
            rsp_sin <= '0;
        end else begin
            if (state == IDLE && found) begin
                id_q <= pick;
                ptr <= (pick == ID_W'(NREQ - 1)) ? '0 : pick + 1'b1;
                angle_q <= req_angle[pick*ANGLE_W +: ANGLE_W];
            end
            first_q <= state == START;
            if (done_ok) begin
                rsp_cos <= cor_cos;
                rsp_sin <= cor_sin;
            end else if (expire) begin
                rsp_cos <= '0;
                rsp_sin <= '0;
            end
            if (done_ok || expire) rsp_id <= id_q;
        end
    end
`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
    logic err_q, sticky_q;
    // the TIMEOUT-th WAIT cycle without a done aborts; a simultaneous done still wins
    assign expire = state == WAIT && !done_ok && cnt == CNT_W'(TIMEOUT - 1);
    assign rsp_err = err_q;
    assign err_timeout = sticky_q;
    // watchdog counter and sticky error flags
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            err_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            cnt <= (state == START) ? '0 : (state == WAIT) ? cnt + 1'b1 : cnt;
            if (done_ok) err_q <= 1'b0;
            else if (expire) begin
                err_q <= 1'b1;
                sticky_q <= 1'b1;
            end
        end
    end
`else
    assign expire = 1'b0;
    assign rsp_err = 1'b0;
    assign err_timeout = 1'b0;
`endif
endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Round-robin arbiter and sequencer that shares one `cordic` core among `NREQ` requesters. It latches the winning requester's angle and drives the core's `z0`/`start` handshake. It waits for `done`, then returns the captured cos/sin results tagged with the requester id. It sits between the per-channel front ends and the single `cordic` instance, and it owns every `start` pulse the core receives.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `ID_W`, 2: width of `rsp_id`; `NREQ <= 2**ID_W`.
- `ANGLE_W`, 10: signed requester angle width; `ANGLE_W <= 32`.
- `RES_W`, 17: signed cos/sin result width, matching the core outputs.
- `TIMEOUT`, 64: WAIT watchdog limit in cycles; used only with `CORDIC_ARB_TIMEOUT_EN`.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in `NREQ`: level request, bit i per requester.
- `req_angle` in `NREQ*ANGLE_W`: requester i's angle at `[i*ANGLE_W +: ANGLE_W]`.
- `ack` out `NREQ`: one-hot, one-cycle pulse; the request is accepted and the angle is latched.
- `rsp_valid` out 1: one-cycle result strobe.
- `rsp_id` out `ID_W`: requester index of the result.
- `rsp_cos`, `rsp_sin` out `RES_W`: captured core results.
- `rsp_err` out 1: result aborted by the watchdog.
- `busy` out 1: high when the state is not IDLE.
- `cor_start` out 1: core start pulse.
- `cor_z0` out 32: core angle, equal to `{angle_q, (32-ANGLE_W)'b0}`.
- `cor_done` in 1: core done level.
- `cor_cos`, `cor_sin` in `RES_W`: core results.
- `err_timeout` out 1: sticky watchdog flag.

## Operation
- Registered FSM with states IDLE, START, WAIT, RESP.
- IDLE:
  - If `req` is nonzero, pick the first asserted bit searching from `ptr` upward and wrapping modulo `NREQ`.
  - Latch the winner's id into `id_q` and its angle into `angle_q`.
  - Set `ptr <= (id+1) mod NREQ`.
  - Go to START.
  - If no request is asserted, stay in IDLE and keep `ptr` unchanged.
- START, exactly 1 cycle:
  - `cor_start=1` and `ack[id_q]=1`.
  - `cor_z0` is valid from this cycle and held stable until the next START.
  - Go to WAIT; clear the watchdog counter.
- WAIT:
  - `cor_done` is ignored in the first WAIT cycle, because a stale done can remain from the previous operation.
  - From the second WAIT cycle onward, `cor_done=1` captures `cor_cos` and `cor_sin` into the response registers, clears `rsp_err`, and moves to RESP.
- RESP, exactly 1 cycle:
  - `rsp_valid=1`, with `rsp_id=id_q` and the data held.
  - Go to IDLE.
- Requesters hold `req` until they see their `ack`.
  - A request still high after its ack is treated as a new request.
  - That new request competes through round-robin again.
- `req` changes outside IDLE have no effect.
- `req_angle` is sampled only in the IDLE grant cycle.
- `rsp_cos`, `rsp_sin`, `rsp_id` and `rsp_err` hold their last values between strobes.
- `cor_z0` holds `angle_q` at all times.

## Timing
- Reset, any state including mid-operation:
  - State goes to IDLE and `ptr=0`.
  - `ack`, `rsp_valid`, `cor_start`, `busy`, `rsp_err` and `err_timeout` are 0.
  - `rsp_id`, `rsp_cos`, `rsp_sin`, `angle_q` and `cor_z0` are 0.
  - An in-flight core operation is abandoned; the core is reset by its own reset.
- With `req` sampled in IDLE at cycle T:
  - `ack` and `cor_start` are high in cycle T+1.
  - WAIT begins at T+2.
  - The earliest accepted `cor_done` is at T+3.
- If `cor_done` is accepted at cycle D:
  - `rsp_valid` is high at D+1.
  - IDLE is entered at D+2.
  - The next `ack` comes no earlier than D+3.
- `busy` is registered and is high from T+1 through D+1.
- Simultaneous requests are granted in rotating order, so each requester waits at most `NREQ-1` services.

## Configuration
- Macro: `CORDIC_ARB_TIMEOUT_EN`.
- When defined:
  - A counter increments every WAIT cycle.
  - If `TIMEOUT` WAIT cycles pass without an accepted done, go to RESP with `rsp_err=1` and `rsp_cos=rsp_sin=0`.
  - Set `err_timeout=1`; it stays set until reset.
  - A done arriving in the same cycle the counter expires wins, and the response is a normal one.
- When undefined:
  - WAIT lasts indefinitely.
  - `rsp_err` and `err_timeout` are tied to 0.
  - No counter logic is built.

## Test plan
- **Reset behaviour:** reset asserted then released with `req=0`. Required: all outputs 0, `busy=0`, and no `cor_start` for 20 cycles.
- **Single request:** `req=4'b0100`, angle=10'sd45, core model raises done 16 cycles after start with cos=17'sd181. Required:
  - `ack=4'b0100` and `cor_z0=32'h0B400000`, one cycle after the request.
  - `rsp_valid` with `rsp_id=2`, `rsp_cos=181` and `rsp_err=0`, one cycle after done.
- **Round-robin fairness:** `req=4'b1111` held, with each requester dropping its bit after its ack. Required: ack order 0,1,2,3, then a fresh `4'b1001` is granted to 0 then 3 (ptr=0 after requester 3's grant).
- **Stale done:** `cor_done` held high through START and the first WAIT cycle, then low, then high at WAIT+5. Required: the capture occurs only at WAIT+5.
- **Reset mid-operation:** reset asserted in WAIT. Required:
  - Next cycle is IDLE with `busy=0` and `rsp_valid` never pulses.
  - A subsequent `req=4'b0010` is acked as requester 1.
- **Watchdog (`CORDIC_ARB_TIMEOUT_EN`, `TIMEOUT=64`):** core never raises done. Required:
  - `rsp_valid` with `rsp_err=1` and cos=sin=0 after 64 WAIT cycles.
  - `err_timeout` stays 1 until reset.
